voice_mixer: RTL and testbench
==============================

VOICE_MIXER -- requirements
Module: voice_mixer

Interface
REQ-001 SHALL have parameter SAMPLE_DIV, default 1042, clk cycles per output sample (50 MHz / 1042 ≈ 48 kHz); legal range 8..4095.
REQ-002 SHALL have port clk, input, 1 bit: system clock (50 MHz); the sole clock; all state updates on its rising edge.
REQ-003 SHALL have port reset_n, input, 1 bit: reset, synchronous and active-high (1 = reset).
REQ-004 SHALL have port voice_samples, input, 32 bits: four unsigned 8-bit voice samples from the wave creators; voice i at bits [8i+7:8i].
REQ-005 SHALL have port voice_enable, input, 4 bits: bit i = voice i sounding.
REQ-006 SHALL have port vol_up, input, 1 bit: volume increment request (level, from an arrow key).
REQ-007 SHALL have port vol_down, input, 1 bit: volume decrement request (level).
REQ-008 SHALL have port write_ready, input, 1 bit: codec can accept a sample.
REQ-009 SHALL have port write, output, 1 bit: one-cycle sample write strobe to the codec.
REQ-010 SHALL have port writedata_left, output, 24 bits: signed sample to the codec.
REQ-011 SHALL have port writedata_right, output, 24 bits: signed sample; always equal to writedata_left.
REQ-012 SHALL have port volume, output, 3 bits: current volume, 0..7.
REQ-013 SHALL have port active, output, 1 bit: at least one voice was enabled in the last captured sample.
REQ-014 SHALL have port overrun, output, 1 bit: sticky flag, set when a sample tick was dropped.

Function
REQ-015 Tick counter SHALL count 0..SAMPLE_DIV-1 and wrap to 0; tick = 1 in the cycle the count equals SAMPLE_DIV-1.
REQ-016 FSM states SHALL be IDLE, CAPTURE, SUM, SCALE, SEND; tick in IDLE -> CAPTURE; then CAPTURE -> SUM -> SCALE -> SEND, one cycle each.
REQ-017 CAPTURE SHALL register voice_samples and voice_enable; active updates to the OR of the captured enables.
REQ-018 SUM SHALL convert each enabled sample to signed (sample - 128), contribute 0 for each disabled voice, and sum all four into 11-bit signed (range -512..508).
REQ-019 SCALE SHALL multiply the sum by the volume value current in that cycle, shift left by 11, sign-extend to 24 bits, and load both writedata outputs.
REQ-020 SEND SHALL hold writedata stable and wait; write = 1 exactly in the SEND cycle where write_ready = 1; next state is IDLE.
REQ-021 Latency: tick at cycle T gives earliest write at cycle T+4.
REQ-022 A tick arriving while state is not IDLE SHALL be dropped (no sample queued) and SHALL set overrun; overrun clears only on reset.
REQ-023 writedata SHALL change only in SCALE.
REQ-024 Volume: rising edge of vol_up increments, saturating at 7; rising edge of vol_down decrements, saturating at 0; both rising edges in the same cycle = no change; held levels give one step only.
REQ-025 With no voices enabled, the FSM SHALL still issue a write, with writedata = 0.

Reset
REQ-026 While reset_n = 1: state = IDLE, tick counter = 0, write = 0, writedata_left/right = 0, volume = 4, active = 0, overrun = 0, edge-detect history = 0.
REQ-027 Reset asserted in any state SHALL abort the sample in progress; no write issues for it.

Verification (SAMPLE_DIV = 16)
REQ-028 Voice0 = 255 enabled, others disabled, volume 4, write_ready = 1 -> write is a single pulse at tick+4; writedata = 0x0FE000 on both channels.
REQ-029 All four voices = 0 enabled, volume raised to 7 -> writedata = 0x900000 (-3584 << 11); active = 1.
REQ-030 write_ready held 0 for 40 cycles -> write stays 0; writedata stable; overrun = 1 after the next tick; when ready rises, exactly one write.
REQ-031 vol_up held high 5 cycles -> volume 4 -> 5; five separate pulses -> volume saturates at 7; vol_up and vol_down rising together -> volume unchanged.
REQ-032 voice_enable = 0 -> write still pulses; writedata = 0; active = 0.
REQ-033 reset_n pulsed during SCALE -> no write; all outputs at their REQ-026 reset values; next tick processes normally.

Source files
------------

// File: rtl/voice_mixer.sv
// voice_mixer: sums four 8-bit voices, scales by a 0..7 volume and writes 24-bit samples to a codec
module voice_mixer #(
   parameter int SAMPLE_DIV = 1042
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [31:0] voice_samples,
   input  logic [3:0]  voice_enable,
   input  logic        vol_up,
   input  logic        vol_down,
   input  logic        write_ready,
   output logic        write,
   output logic [23:0] writedata_left,
   output logic [23:0] writedata_right,
   output logic [2:0]  volume,
   output logic        active,
   output logic        overrun
);
   typedef enum logic [2:0] {IDLE, CAPTURE, SUM, SCALE, SEND} state_t;
   localparam logic [11:0] LAST = 12'(SAMPLE_DIV - 1);
   state_t             state_q, state_d;
   logic [11:0]        cnt_q, cnt_d;
   logic [31:0]        smp_q, smp_d;
   logic [3:0]         en_q, en_d;
   logic signed [10:0] sum_q, sum_d, acc;
   logic signed [12:0] prod;
   logic [23:0]        wd_q, wd_d;
   logic [2:0]         vol_q, vol_d;
   logic               active_q, active_d, overrun_q, overrun_d;
   logic               up_q, up_d, dn_q, dn_d;
   logic               tick, up_rise, dn_rise;
   // sample-rate divider: tick marks the last count of each period
   always_comb begin
      tick  = cnt_q == LAST;
      cnt_d = tick ? 12'd0 : cnt_q + 12'd1;
   end
   // sequencing: one sample walks capture -> sum -> scale -> send
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    state_d = tick ? CAPTURE : IDLE;
         CAPTURE: state_d = SUM;
         SUM:     state_d = SCALE;
         SCALE:   state_d = SEND;
         SEND:    state_d = write_ready ? IDLE : SEND;
         default: state_d = IDLE;
      endcase
   end
   // datapath: capture inputs, sum offset-binary voices, scale into the top bits of the codec word
   always_comb begin
      acc = '0;
      for (int i = 0; i < 4; i++)
         acc = acc + (en_q[i] ? $signed({3'b000, smp_q[8*i +: 8]}) - 11'sd128 : 11'sd0);
      prod      = 13'(sum_q) * 13'($signed({1'b0, vol_q}));
      smp_d     = state_q == CAPTURE ? voice_samples : smp_q;
      en_d      = state_q == CAPTURE ? voice_enable : en_q;
      active_d  = state_q == CAPTURE ? |voice_enable : active_q;
      sum_d     = state_q == SUM ? acc : sum_q;
      wd_d      = state_q == SCALE ? {prod, 11'd0} : wd_q;
      overrun_d = overrun_q | (tick & (state_q != IDLE));
   end
   // volume: act on rising edges only; simultaneous up/down edges cancel
   always_comb begin
      up_d    = vol_up;
      dn_d    = vol_down;
      up_rise = vol_up & ~up_q;
      dn_rise = vol_down & ~dn_q;
      vol_d   = (up_rise & ~dn_rise & (vol_q != 3'd7)) ? vol_q + 3'd1 :
                (dn_rise & ~up_rise & (vol_q != 3'd0)) ? vol_q - 3'd1 : vol_q;
   end
   // state registers with synchronous active-high reset
   always_ff @(posedge clk) begin
      if (reset_n) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         smp_q     <= '0;
         en_q      <= '0;
         sum_q     <= '0;
         wd_q      <= '0;
         vol_q     <= 3'd4;
         active_q  <= 1'b0;
         overrun_q <= 1'b0;
         up_q      <= 1'b0;
         dn_q      <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         smp_q     <= smp_d;
         en_q      <= en_d;
         sum_q     <= sum_d;
         wd_q      <= wd_d;
         vol_q     <= vol_d;
         active_q  <= active_d;
         overrun_q <= overrun_d;
         up_q      <= up_d;
         dn_q      <= dn_d;
      end
   end
   assign write           = (state_q == SEND) & write_ready & ~reset_n;
   assign writedata_left  = wd_q;
   assign writedata_right = wd_q;
   assign volume          = vol_q;
   assign active          = active_q;
   assign overrun         = overrun_q;
endmodule

// File: tb/tb_voice_mixer.sv
// tb_voice_mixer: directed checks of voice_mixer at SAMPLE_DIV = 16
module tb_voice_mixer;
   logic        clk = 1'b0;
   logic        reset_n, vol_up, vol_down, write_ready, write, active, overrun;
   logic [31:0] voice_samples;
   logic [3:0]  voice_enable;
   logic [23:0] writedata_left, writedata_right;
   logic [2:0]  volume;
   int          checks = 0;
   int          failures = 0;
   voice_mixer #(.SAMPLE_DIV(16)) dut (
      .clk(clk), .reset_n(reset_n), .voice_samples(voice_samples), .voice_enable(voice_enable),
      .vol_up(vol_up), .vol_down(vol_down), .write_ready(write_ready), .write(write),
      .writedata_left(writedata_left), .writedata_right(writedata_right), .volume(volume),
      .active(active), .overrun(overrun)
   );
   always #5 clk = ~clk;
   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask
   task automatic chk(input string tag, input logic [23:0] obs, input logic [23:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask
   task automatic chk_reset(input string tag);
      chk({tag, "_write"}, 24'(write), 24'd0);
      chk({tag, "_wdl"}, writedata_left, 24'd0);
      chk({tag, "_wdr"}, writedata_right, 24'd0);
      chk({tag, "_vol"}, 24'(volume), 24'd4);
      chk({tag, "_active"}, 24'(active), 24'd0);
      chk({tag, "_overrun"}, 24'(overrun), 24'd0);
   endtask
   initial begin
      reset_n = 1'b1;
      vol_up = 1'b0;
      vol_down = 1'b0;
      write_ready = 1'b1;
      voice_samples = {8'h00, 8'h00, 8'h00, 8'hFF};
      voice_enable = 4'b0001;
      step(3);
      chk_reset("rst");
      // P: counter is 0 after this edge; first tick at P+15, write at P+19
      reset_n = 1'b0;
      step(18);
      chk("lat_early", 24'(write), 24'd0);
      step(1);
      chk("v0_write", 24'(write), 24'd1);
      chk("v0_wdl", writedata_left, 24'h0FE000);
      chk("v0_wdr", writedata_right, 24'h0FE000);
      chk("v0_active", 24'(active), 24'd1);
      step(1);
      chk("v0_single", 24'(write), 24'd0);
      // P+20: no voices enabled, write at P+35
      voice_enable = 4'b0000;
      step(15);
      chk("none_write", 24'(write), 24'd1);
      chk("none_wd", writedata_left, 24'd0);
      chk("none_active", 24'(active), 24'd0);
      step(1);
      // P+36: held vol_up gives one step
      vol_up = 1'b1;
      step(5);
      chk("vol_held", 24'(volume), 24'd5);
      vol_up = 1'b0;
      step(1);
      for (int i = 0; i < 5; i++) begin
         vol_up = 1'b1;
         step(1);
         vol_up = 1'b0;
         step(1);
      end
      chk("vol_sat", 24'(volume), 24'd7);
      // P+52: all voices at 0, volume 7, write at P+67
      voice_samples = 32'h0;
      voice_enable = 4'b1111;
      step(15);
      chk("min_write", 24'(write), 24'd1);
      chk("min_wdl", writedata_left, 24'h900000);
      chk("min_wdr", writedata_right, 24'h900000);
      chk("min_active", 24'(active), 24'd1);
      step(1);
      vol_down = 1'b1;
      step(1);
      chk("vol_down", 24'(volume), 24'd6);
      vol_down = 1'b0;
      step(1);
      vol_up = 1'b1;
      vol_down = 1'b1;
      step(1);
      chk("vol_both", 24'(volume), 24'd6);
      vol_up = 1'b0;
      vol_down = 1'b0;
      step(1);
      // P+72: codec stalls; sample loads at P+82, tick at P+95 is dropped
      write_ready = 1'b0;
      step(11);
      chk("stall_write0", 24'(write), 24'd0);
      chk("stall_wd0", writedata_left, 24'hA00000);
      chk("stall_ovr0", 24'(overrun), 24'd0);
      step(13);
      chk("stall_ovr1", 24'(overrun), 24'd1);
      chk("stall_write1", 24'(write), 24'd0);
      step(16);
      chk("stall_write2", 24'(write), 24'd0);
      chk("stall_wd2", writedata_right, 24'hA00000);
      chk("stall_ovr2", 24'(overrun), 24'd1);
      write_ready = 1'b1;
      #1;
      chk("ready_write", 24'(write), 24'd1);
      step(1);
      chk("ready_single", 24'(write), 24'd0);
      // P+113: tick at P+127, SCALE in the cycle after P+130
      step(17);
      chk("pre_abort", 24'(write), 24'd0);
      reset_n = 1'b1;
      step(1);
      chk_reset("abort");
      voice_samples = {8'h10, 8'h33, 8'h90, 8'hFF};
      voice_enable = 4'b1010;
      reset_n = 1'b0;
      step(18);
      chk("post_early", 24'(write), 24'd0);
      step(1);
      chk("post_write", 24'(write), 24'd1);
      chk("post_wdl", writedata_left, 24'hF40000);
      chk("post_wdr", writedata_right, 24'hF40000);
      chk("post_active", 24'(active), 24'd1);
      chk("post_ovr", 24'(overrun), 24'd0);
      step(1);
      chk("post_single", 24'(write), 24'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
